// File: rtl/qr_result_collector_pkg.sv
// rtl/qr_result_collector_pkg.sv - shared sizes and FSM states for the QR result collector
package qr_result_collector_pkg;

   localparam int W             = 32;
   localparam int N_EL          = 16;
   localparam int MAT_W         = N_EL * W;
   localparam int WORDS_PER_RES = 2 * N_EL;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

endpackage

// File: rtl/qr_result_collector_if.sv
// rtl/qr_result_collector_if.sv - QR-core result input and serialized word output bundle
interface qr_result_collector_if #(
   parameter int W    = 32,
   parameter int N_EL = 16
);
   logic              ready_out;
   logic [N_EL*W-1:0] Q_matrix;
   logic [N_EL*W-1:0] R_matrix;
   logic              accept_in;
   logic [W-1:0]      word_data;
   logic              word_valid;
   logic              word_ready;
   logic              word_sel_r;
   logic              word_last;

   // master: QR core plus word consumer; slave: the collector
   modport master (
      output ready_out, Q_matrix, R_matrix, word_ready,
      input  accept_in, word_data, word_valid, word_sel_r, word_last
   );

   modport slave (
      input  ready_out, Q_matrix, R_matrix, word_ready,
      output accept_in, word_data, word_valid, word_sel_r, word_last
   );
endinterface

// File: rtl/qr_result_collector_word_mux.sv
// rtl/qr_result_collector_word_mux.sv - picks one word of a {R,Q} buffer entry by index
module qr_word_mux #(
   parameter int W     = 32,
   parameter int N_EL  = 16,
   parameter int IDX_W = $clog2(2 * N_EL)
) (
   input  logic [2*N_EL*W-1:0] entry_i,
   input  logic [IDX_W-1:0]    idx_i,
   output logic [W-1:0]        word_o
);

   // {R,Q} packing makes idx 0..N_EL-1 hit Q and the upper half hit R directly
   assign word_o = entry_i[idx_i*W +: W];

endmodule

// File: rtl/qr_result_collector.sv
// rtl/qr_result_collector.sv - two-entry QR result buffer serialized as Q then R words
module qr_result_collector #(
   parameter int W    = qr_result_collector_pkg::W,
   parameter int N_EL = qr_result_collector_pkg::N_EL
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         enable,
   qr_result_collector_if.slave         bus,
   output logic [15:0]                  frame_count
);
   import qr_result_collector_pkg::*;

   localparam int ENT_W = 2 * N_EL * W;
   localparam int IDX_W = $clog2(2 * N_EL);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2 * N_EL - 1);

   logic [ENT_W-1:0] buf_q [2];
   state_e           state_q;
   logic [1:0]       count_q, count_d;
   logic             wr_ptr_q, rd_ptr_q;
   logic [IDX_W-1:0] idx_q;
   logic [15:0]      frame_q;
   logic             accept_q;
   logic [W-1:0]     word_data;
   logic             push, pop, last_pop;

   assign bus.accept_in  = accept_q && enable;
   assign bus.word_valid = (state_q == SEND) && enable;
   assign bus.word_sel_r = idx_q[IDX_W-1];
   assign bus.word_last  = (idx_q == LAST_IDX);
   assign bus.word_data  = word_data;
   assign frame_count    = frame_q;

   assign push     = bus.ready_out && bus.accept_in;
   assign pop      = bus.word_valid && bus.word_ready;
   assign last_pop = pop && (idx_q == LAST_IDX);

   always_comb begin
      count_d = count_q + 2'(push) - 2'(last_pop);
   end

   // buffer payload is not reset; count/pointers alone decide what is live
   always_ff @(posedge clk) begin
      if (push) begin
         buf_q[wr_ptr_q] <= {bus.R_matrix, bus.Q_matrix};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         count_q  <= 2'd0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         idx_q    <= '0;
         frame_q  <= 16'd0;
         accept_q <= 1'b0;
      end else if (enable) begin
         count_q  <= count_d;
         accept_q <= (count_d != 2'd2);
         if (push) begin
            wr_ptr_q <= ~wr_ptr_q;
         end
         if (pop) begin
            idx_q <= last_pop ? '0 : idx_q + 1'b1;
         end
         if (last_pop) begin
            rd_ptr_q <= ~rd_ptr_q;
            frame_q  <= frame_q + 16'd1;
         end
         // looking at count_d lets the first word go out one cycle after capture
         case (state_q)
            IDLE: if (count_d != 2'd0) state_q <= SEND;
            SEND: if (last_pop && count_d == 2'd0) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   qr_word_mux #(
      .W     (W),
      .N_EL  (N_EL),
      .IDX_W (IDX_W)
   ) u_word_mux (
      .entry_i (buf_q[rd_ptr_q]),
      .idx_i   (idx_q),
      .word_o  (word_data)
   );

endmodule

// File: tb/tb_qr_result_collector.sv
// tb/tb_qr_result_collector.sv - directed bench for qr_result_collector
module tb_qr_result_collector;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [15:0] frame_count;
   int          passed = 0;
   int          total  = 0;

   always #5 clk = ~clk;

   qr_result_collector_if #(.W(32), .N_EL(16)) bus ();

   qr_result_collector #(.W(32), .N_EL(16)) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .bus         (bus),
      .frame_count (frame_count)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   function automatic logic [31:0] ew(input int n, input int i);
      logic [31:0] base;
      base = (i < 16) ? 32'h0100_0000 : 32'h0200_0000;
      return base + 32'(n << 16) + 32'(i % 16);
   endfunction

   task automatic load(input int n);
      for (int k = 0; k < 16; k++) begin
         bus.Q_matrix[32*k +: 32] = 32'h0100_0000 + 32'(n << 16) + 32'(k);
         bus.R_matrix[32*k +: 32] = 32'h0200_0000 + 32'(n << 16) + 32'(k);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_word(input string tag, input int n, input int i);
      logic [4:0] ii;
      ii = 5'(i);
      chk(tag, {bus.word_valid, bus.word_sel_r, bus.word_last, bus.word_data},
          {1'b1, ii[4], (i == 31), ew(n, i)});
   endtask

   task automatic drain(input string tag, input int n, input int from, input int to);
      for (int i = from; i <= to; i++) begin
         chk_word(tag, n, i);
         tick();
      end
   endtask

   task automatic capture(input int n);
      load(n);
      bus.ready_out = 1'b1;
      tick();
      bus.ready_out = 1'b0;
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int i;
      int cyc;

      reset          = 1'b1;
      enable         = 1'b1;
      bus.ready_out  = 1'b0;
      bus.word_ready = 1'b0;
      bus.Q_matrix   = '0;
      bus.R_matrix   = '0;
      tick();
      tick();
      chk("rst_accept", bus.accept_in, 0);
      chk("rst_valid", bus.word_valid, 0);
      chk("rst_last", bus.word_last, 0);
      chk("rst_sel", bus.word_sel_r, 0);
      chk("rst_frame", frame_count, 0);

      reset = 1'b0;
      #1;
      chk("accept_before_edge", bus.accept_in, 0);
      tick();
      chk("accept_after_edge", bus.accept_in, 1);

      // single result, continuous ready
      bus.word_ready = 1'b1;
      capture(0);
      drain("single", 0, 0, 31);
      chk("single_frame", frame_count, 1);
      chk("single_idle", bus.word_valid, 0);

      // backpressure with three results
      bus.word_ready = 1'b0;
      load(1);
      bus.ready_out = 1'b1;
      tick();
      load(2);
      #1;
      chk("bp_accept_one", bus.accept_in, 1);
      tick();
      load(3);
      #1;
      chk("bp_full", bus.accept_in, 0);
      tick();
      tick();
      chk("bp_still_full", bus.accept_in, 0);
      chk_word("bp_hold", 1, 0);
      bus.word_ready = 1'b1;
      #1;
      for (int k = 0; k < 32; k++) begin
         chk_word("bp_r1", 1, k);
         if (k == 31) chk("bp_full_at_last", bus.accept_in, 0);
         tick();
      end
      chk("bp_reopen", bus.accept_in, 1);
      chk_word("bp_r2", 2, 0);
      tick();
      bus.ready_out = 1'b0;
      #1;
      drain("bp_r2", 2, 1, 31);
      drain("bp_r3", 3, 0, 31);
      chk("bp_frame", frame_count, 4);
      chk("bp_idle", bus.word_valid, 0);

      // random stalls
      bus.word_ready = 1'b0;
      capture(4);
      i   = 0;
      cyc = 0;
      while (i < 32 && cyc < 1000) begin
         bus.word_ready = 1'($urandom_range(0, 1));
         #1;
         chk_word("stall", 4, i);
         tick();
         if (bus.word_ready) i++;
         cyc++;
      end
      chk("stall_done", i, 32);
      chk("stall_frame", frame_count, 5);

      // capture coinciding with last-word pop at count=1
      bus.word_ready = 1'b1;
      capture(5);
      drain("sim_r5", 5, 0, 30);
      load(6);
      bus.ready_out = 1'b1;
      #1;
      chk("sim_accept", bus.accept_in, 1);
      chk_word("sim_r5", 5, 31);
      tick();
      bus.ready_out = 1'b0;
      #1;
      drain("sim_r6", 6, 0, 31);
      chk("sim_count_one", bus.word_valid, 0);
      chk("sim_frame", frame_count, 7);

      // reset mid-result at idx 10
      capture(7);
      drain("rst_r7", 7, 0, 9);
      chk_word("rst_r7", 7, 10);
      reset = 1'b1;
      #1;
      chk("mid_rst_valid", bus.word_valid, 0);
      chk("mid_rst_frame", frame_count, 0);
      chk("mid_rst_accept", bus.accept_in, 0);
      tick();
      reset = 1'b0;
      #1;
      chk("post_rst_valid", bus.word_valid, 0);
      tick();
      chk("post_rst_accept", bus.accept_in, 1);
      chk("post_rst_empty", bus.word_valid, 0);
      capture(8);
      drain("rst_r8", 8, 0, 31);
      chk("rst_frame_one", frame_count, 1);

      // enable low for 5 cycles mid-result
      capture(9);
      drain("en_r9", 9, 0, 4);
      enable = 1'b0;
      load(10);
      bus.ready_out = 1'b1;
      #1;
      for (int c = 0; c < 5; c++) begin
         chk("en_low_valid", bus.word_valid, 0);
         chk("en_low_accept", bus.accept_in, 0);
         tick();
      end
      enable = 1'b1;
      bus.ready_out = 1'b0;
      #1;
      drain("en_r9", 9, 5, 31);
      chk("en_no_capture", bus.word_valid, 0);
      chk("en_frame", frame_count, 2);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/qr_result_collector.md
QR_RESULT_COLLECTOR -- requirements
Module: qr_result_collector

Interface
REQ-001 SHALL have parameter W, default 32, meaning width of one matrix element word.
REQ-002 SHALL have parameter N_EL, default 16, meaning elements per matrix (512 = N_EL*W).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  block enable; low freezes all state.
REQ-006 ready_out  input  1  QR core result valid.
REQ-007 Q_matrix  input  512  Q result; element k at bits [32k+31:32k].
REQ-008 R_matrix  input  512  R result; same element packing.
REQ-009 accept_in  output  1  to QR core: collector can take a result.
REQ-010 word_data  output  32  serialized element word.
REQ-011 word_valid  output  1  word_data valid.
REQ-012 word_ready  input  1  downstream accepts word.
REQ-013 word_sel_r  output  1  0 = current word from Q, 1 = from R.
REQ-014 word_last  output  1  final word (index 31) of current result.
REQ-015 frame_count  output  16  completed results sent, wraps at 65535->0.

Function
REQ-016 SHALL hold a 2-entry buffer, each entry 1024 bits {R_matrix, Q_matrix}, with 1-bit wr_ptr, 1-bit rd_ptr, 2-bit count.
REQ-017 accept_in SHALL equal (count != 2) && enable, driven from registers only, no combinational path from ready_out or word_ready.
REQ-018 Capture SHALL occur on a rising edge where enable && ready_out && accept_in: entry[wr_ptr] loaded, wr_ptr toggles, count increments.
REQ-019 ready_out while accept_in low SHALL NOT capture; QR core holds its result (no drop, no error flag).
REQ-020 FSM SHALL have states IDLE and SEND; IDLE->SEND when count != 0; SEND->IDLE after last-word handshake with no remaining entry; SEND->SEND on last-word handshake when another entry is buffered.
REQ-021 word_valid SHALL be 1 exactly in SEND with enable high.
REQ-022 Word index idx (5 bits, 0..31) SHALL select word_data: idx 0..15 = Q element idx, idx 16..31 = R element idx-16, from entry[rd_ptr].
REQ-023 word_sel_r SHALL equal idx[4]; word_last SHALL equal (idx == 31).
REQ-024 A handshake (word_valid && word_ready) SHALL advance idx by 1; on idx 31 it SHALL wrap idx to 0, toggle rd_ptr, decrement count, increment frame_count.
REQ-025 Latency: first word_valid SHALL appear one cycle after the capture edge; a result drains in 32 cycles minimum under continuous word_ready.
REQ-026 Simultaneous capture and last-word pop in one cycle SHALL leave count unchanged and both pointers toggled.
REQ-027 word_ready low SHALL hold word_data, idx, word_valid stable.
REQ-028 enable low SHALL freeze all registers, force word_valid and accept_in low; resume with state intact.

Reset
REQ-029 While reset is high: count=0, wr_ptr=0, rd_ptr=0, idx=0, frame_count=0, FSM=IDLE, word_valid=0, accept_in=0, word_last=0, word_sel_r=0.
REQ-030 Reset mid-transfer SHALL discard all buffered results; buffer data contents need not be cleared.
REQ-031 After reset deassertion accept_in SHALL rise on the first edge state is visible with enable high.

Structure
REQ-032 Shared package SHALL hold W, N_EL, MAT_W=512, WORDS_PER_RES=32, and the FSM state enumeration.
REQ-033 One sub-module qr_word_mux (1024-bit entry + 5-bit index -> 32-bit word) SHALL implement REQ-022.

Verification
REQ-034 Single result: Q element k = 32'h0100_0000+k, R element k = 32'h0200_0000+k, word_ready=1 -> 32 words in order, word_last only on 32'h0200_000F, frame_count=1.
REQ-035 Backpressure: three results back-to-back with word_ready=0 -> accept_in low after second capture, third held until first word_last handshake, then captured; all 96 words correct in order.
REQ-036 Random word_ready stall (50%) -> word_data stable while stalled, no repeated or skipped index.
REQ-037 Simultaneous capture and pop with count=1 -> count stays 1, next word is index 0 of new result.
REQ-038 Reset asserted at idx=10 -> word_valid low same cycle, after release count=0, frame_count=0, next result starts at index 0.
REQ-039 enable low for 5 cycles mid-result -> no word_valid, no capture; resumes at same idx.
